z80_wait_ctrl: RTL and testbench
================================

Name: z80_wait_ctrl

Overview:
- Z80 /WAIT sequencer for the MSX core.
- Inserts fixed wait states on M1 (opcode fetch) and interrupt-acknowledge cycles, and on VDP I/O ports.
- Stretches cycles for slow external devices, with a timeout watchdog.
- Sits between CPU bus decode and the CPU WAIT input.
- All timing is counted in CPU T-states via a clock enable.

Parameters:
- M1_WAITS, 1, wait T-states added to M1 and INTA cycles (0..15; 0 means none).
- VDP_WAITS, 2, wait T-states added to I/O cycles on VDP ports (0..15).
- VDP_PORT_BASE, 8'h98, first of four VDP I/O ports (base..base+3).
- EXT_TIMEOUT, 255, maximum T-states an external wait is honoured (1..255).

Ports:
- clk  in  1  system clock
- clr  in  1  asynchronous active-low reset
- cpu_ce  in  1  one-clk pulse per CPU T-state
- m1_n  in  1  Z80 M1
- mreq_n  in  1  Z80 MREQ
- iorq_n  in  1  Z80 IORQ
- addr  in  8  Z80 A[7:0]
- turbo  in  1  1 = suppress M1/INTA waits
- ext_wait_n  in  1  slow-device wait request, active low
- tmo_clr  in  1  clears timeout_flag
- wait_n  out  1  to Z80 WAIT, registered
- timeout_flag  out  1  sticky, set on external-wait timeout
- wait_count  out  16  total inserted wait T-states (see Optional Feature)

Behaviour:
- Reset (clr=0, async): state IDLE, counter 0, wait_n=1, timeout_flag=0, wait_count=0. Reset mid-cycle releases wait_n immediately.
- All FSM transitions and counter updates occur only on clk edges with cpu_ce=1. tmo_clr acts on any clk.
- States: IDLE, INT_WAIT, EXT_WAIT, RELEASE.
- IDLE: cycle classification on a cpu_ce edge:
  - M1 fetch: m1_n=0 and mreq_n=0 → n=M1_WAITS.
  - INTA: m1_n=0 and iorq_n=0 → n=M1_WAITS. INTA has priority; no VDP decode.
  - VDP I/O: m1_n=1, iorq_n=0, addr[7:2]==VDP_PORT_BASE[7:2] → n=VDP_WAITS.
  - Any other cycle with a strobe low → n=0.
  - turbo=1 forces n=0 for M1/INTA only.
  - If n>0: go to INT_WAIT, load counter=n, wait_n=0 on the same edge.
  - If n=0: go to the external check.
- INT_WAIT: decrement counter each cpu_ce. At counter==1, go to the external check. wait_n stays 0 for exactly n cpu_ce periods.
- External check, same edge:
  - ext_wait_n=0 → EXT_WAIT, wait_n=0, timer=0.
  - Otherwise → RELEASE, wait_n=1.
- EXT_WAIT:
  - ext_wait_n sampled 1 → RELEASE, wait_n=1.
  - timer reaches EXT_TIMEOUT → RELEASE, wait_n=1, timeout_flag=1.
  - Otherwise timer+1.
  - Timer is 8 bits; never wraps because it stops at EXT_TIMEOUT.
- RELEASE: wait_n=1. Return to IDLE only when mreq_n=1 and iorq_n=1, so a cycle is never recognised twice.
- Strobes deasserting during INT_WAIT/EXT_WAIT (abnormal): go to RELEASE next cpu_ce, wait_n=1.
- timeout_flag: cleared when tmo_clr=1. If set and clear coincide, set wins.
- Parameters above 15 for M1_WAITS/VDP_WAITS are illegal; the implementation asserts this in simulation.

Optional Feature:
- Macro WAIT_STATS_EN.
- Defined: wait_count increments by 1 on every cpu_ce edge where the registered wait_n is 0. It saturates at 16'hFFFF and resets to 0 on clr.
- Undefined: no counter logic; wait_count is tied to 16'h0000.

Test Plan:
- M1 fetch, M1_WAITS=1, turbo=0, ext_wait_n=1 → wait_n low exactly 1 cpu_ce period. Then RELEASE until mreq_n=1. With WAIT_STATS_EN, wait_count=1.
- Same fetch with turbo=1 → wait_n stays 1. Then OUT to port 8'h99, VDP_WAITS=2 → wait_n low 2 periods. OUT to 8'hA0 → no wait.
- INTA (m1_n=0, iorq_n=0, addr=8'h98) → M1_WAITS waits only, not VDP_WAITS.
- I/O to 8'hA8 with ext_wait_n low for 5 T-states → wait_n low 5 periods, then released; timeout_flag=0.
- ext_wait_n held low, EXT_TIMEOUT=255 → wait_n released after 255 periods, timeout_flag=1. Pulse tmo_clr → flag 0.
- Assert clr while in INT_WAIT mid-count → wait_n=1 asynchronously. After release, the next M1 cycle gets full M1_WAITS waits.

Source files
------------

// File: rtl/z80_wait_ctrl.sv
// z80_wait_ctrl - Z80 /WAIT sequencer for the MSX core.
//
// Adds fixed wait T-states to M1 (opcode fetch) and interrupt-acknowledge
// cycles, and to I/O cycles that hit the four VDP ports. It also stretches
// any cycle for as long as a slow device holds ext_wait_n low, up to a
// timeout. All timing is counted in CPU T-states, which are marked by the
// cpu_ce clock enable.
//
// Optional feature: define WAIT_STATS_EN to build a saturating 16-bit count
// of inserted wait T-states. Without it, wait_count is tied to zero.
//
// Ports:
//   clk           system clock
//   clr           asynchronous active-low reset
//   cpu_ce        one-clk pulse per CPU T-state
//   m1_n          Z80 M1
//   mreq_n        Z80 MREQ
//   iorq_n        Z80 IORQ
//   addr[7:0]     Z80 A[7:0]
//   turbo         1 = no waits on M1/INTA cycles
//   ext_wait_n    slow-device wait request, active low
//   tmo_clr       clears timeout_flag (acts on any clk)
//   wait_n        to Z80 WAIT, registered
//   timeout_flag  sticky, set when an external wait times out
//   wait_count    inserted wait T-states (WAIT_STATS_EN only, else 0)

module z80_wait_ctrl #(
    parameter int unsigned M1_WAITS      = 1,
    parameter int unsigned VDP_WAITS     = 2,
    parameter logic [7:0]  VDP_PORT_BASE = 8'h98,
    parameter int unsigned EXT_TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        cpu_ce,
    input  logic        m1_n,
    input  logic        mreq_n,
    input  logic        iorq_n,
    input  logic [7:0]  addr,
    input  logic        turbo,
    input  logic        ext_wait_n,
    input  logic        tmo_clr,
    output logic        wait_n,
    output logic        timeout_flag,
    output logic [15:0] wait_count
);

    // Out-of-range parameters are stopped at elaboration.
    if (M1_WAITS > 15) begin : g_m1_range
        $error("z80_wait_ctrl: M1_WAITS must be 0..15");
    end
    if (VDP_WAITS > 15) begin : g_vdp_range
        $error("z80_wait_ctrl: VDP_WAITS must be 0..15");
    end
    if (EXT_TIMEOUT < 1 || EXT_TIMEOUT > 255) begin : g_tmo_range
        $error("z80_wait_ctrl: EXT_TIMEOUT must be 1..255");
    end

    localparam logic [3:0] M1_N  = 4'(M1_WAITS);
    localparam logic [3:0] VDP_N = 4'(VDP_WAITS);
    // The timer counts the periods already spent in EXT_WAIT. The release
    // happens on the edge that would make it reach EXT_TIMEOUT, so wait_n
    // is low for exactly EXT_TIMEOUT periods.
    localparam logic [7:0] TMO_LAST = 8'(EXT_TIMEOUT - 1);
    localparam logic [7:0] VDP_MASK = 8'hFC;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INT_WAIT = 2'd1,
        EXT_WAIT = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t     state_reg;
    logic [3:0] count_reg;
    logic [7:0] timer_reg;
    logic       wait_n_reg;
    logic       timeout_flag_reg;

    // Cycle classification
    logic       strobe;
    logic       is_inta;
    logic       is_m1;
    logic       is_vdp;
    logic [3:0] n_load;

    always_comb begin
        strobe  = !mreq_n || !iorq_n;
        is_inta = !m1_n && !iorq_n;
        is_m1   = !m1_n && !mreq_n;
        is_vdp  = m1_n && !iorq_n && ((addr & VDP_MASK) == (VDP_PORT_BASE & VDP_MASK));
        n_load  = 4'd0;
        // INTA and fetch both take the M1 path. INTA drives A[7:0] with
        // arbitrary data, so this path must never fall into the VDP decode.
        if (is_inta || is_m1) begin
            if (!turbo) begin
                n_load = M1_N;
            end
        end else if (is_vdp) begin
            n_load = VDP_N;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg        <= IDLE;
            count_reg        <= 4'd0;
            timer_reg        <= 8'd0;
            wait_n_reg       <= 1'b1;
            timeout_flag_reg <= 1'b0;
        end else begin
            // A timeout set further down overrides this clear.
            if (tmo_clr) begin
                timeout_flag_reg <= 1'b0;
            end
            if (cpu_ce) begin
                unique case (state_reg)
                    IDLE: begin
                        if (strobe) begin
                            if (n_load != 4'd0) begin
                                state_reg  <= INT_WAIT;
                                count_reg  <= n_load;
                                wait_n_reg <= 1'b0;
                            end else if (!ext_wait_n) begin
                                state_reg  <= EXT_WAIT;
                                timer_reg  <= 8'd0;
                                wait_n_reg <= 1'b0;
                            end else begin
                                state_reg  <= RELEASE;
                                wait_n_reg <= 1'b1;
                            end
                        end
                    end
                    INT_WAIT: begin
                        if (!strobe) begin
                            // The CPU abandoned the cycle; never hold it.
                            state_reg  <= RELEASE;
                            wait_n_reg <= 1'b1;
                        end else if (count_reg == 4'd1) begin
                            // The internal waits are done; the external
                            // device may stretch the cycle further.
                            if (!ext_wait_n) begin
                                state_reg  <= EXT_WAIT;
                                timer_reg  <= 8'd0;
                                wait_n_reg <= 1'b0;
                            end else begin
                                state_reg  <= RELEASE;
                                wait_n_reg <= 1'b1;
                            end
                        end else begin
                            count_reg <= count_reg - 4'd1;
                        end
                    end
                    EXT_WAIT: begin
                        if (!strobe || ext_wait_n) begin
                            state_reg  <= RELEASE;
                            wait_n_reg <= 1'b1;
                        end else if (timer_reg == TMO_LAST) begin
                            state_reg        <= RELEASE;
                            wait_n_reg       <= 1'b1;
                            timeout_flag_reg <= 1'b1;
                        end else begin
                            timer_reg <= timer_reg + 8'd1;
                        end
                    end
                    RELEASE: begin
                        wait_n_reg <= 1'b1;
                        // Wait for the strobes to rise so that one bus cycle
                        // is never classified twice.
                        if (!strobe) begin
                            state_reg <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign wait_n       = wait_n_reg;
    assign timeout_flag = timeout_flag_reg;

`ifdef WAIT_STATS_EN
    logic [15:0] wait_count_reg;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            wait_count_reg <= 16'h0000;
        end else if (cpu_ce && !wait_n_reg && (wait_count_reg != 16'hFFFF)) begin
            wait_count_reg <= wait_count_reg + 16'd1;
        end
    end

    assign wait_count = wait_count_reg;
`else
    assign wait_count = 16'h0000;
`endif

endmodule

// File: tb/tb_z80_wait_ctrl.sv
// Testbench for z80_wait_ctrl: directed bus cycles, each with a
// hand-computed number of wait periods, plus a cycle-level model that
// predicts wait_n, timeout_flag and wait_count on every T-state.
`timescale 1ns/1ps

module tb_z80_wait_ctrl;

    localparam int M1_W   = 1;
    localparam int VDP_W  = 2;
    localparam int VBASE  = 'h98;
    localparam int EXT_T  = 255;
`ifdef WAIT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        cpu_ce = 1'b0;
    logic        m1_n = 1'b1;
    logic        mreq_n = 1'b1;
    logic        iorq_n = 1'b1;
    logic [7:0]  addr = 8'h00;
    logic        turbo = 1'b0;
    logic        ext_wait_n = 1'b1;
    logic        tmo_clr = 1'b0;
    logic        wait_n;
    logic        timeout_flag;
    logic [15:0] wait_count;

    int n_checks = 0;
    int n_fail   = 0;

    z80_wait_ctrl #(
        .M1_WAITS      (M1_W),
        .VDP_WAITS     (VDP_W),
        .VDP_PORT_BASE (8'h98),
        .EXT_TIMEOUT   (EXT_T)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .cpu_ce       (cpu_ce),
        .m1_n         (m1_n),
        .mreq_n       (mreq_n),
        .iorq_n       (iorq_n),
        .addr         (addr),
        .turbo        (turbo),
        .ext_wait_n   (ext_wait_n),
        .tmo_clr      (tmo_clr),
        .wait_n       (wait_n),
        .timeout_flag (timeout_flag),
        .wait_count   (wait_count)
    );

    always #5 clk = ~clk;

    // One T-state every third clock.
    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 3;
            cpu_ce = (div == 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, expected finish within 1 ms");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // ---------------- model ----------------
    // Driver announces a new bus cycle by bumping cyc_seq and publishing the
    // predicted number of low periods (exp_k) and whether it times out.
    int  cyc_seq = 0;
    int  exp_k   = 0;
    bit  exp_tmo = 1'b0;

    int          seen_seq = 0;
    bit          cyc_active = 1'b0;
    int          edge_j = 0;
    logic        exp_wn = 1'b1;
    logic        exp_flag = 1'b0;
    logic [15:0] exp_wc = 16'h0000;

    // Fixed waits implied by the cycle type.
    function automatic int model_n(input logic v_m1, input logic v_mreq, input logic v_iorq,
                                   input logic [7:0] v_addr, input logic v_turbo);
        int a;
        a = int'(v_addr);
        if (!v_m1 && (!v_iorq || !v_mreq)) return v_turbo ? 0 : M1_W;
        if (v_m1 && !v_iorq && a >= VBASE && a <= VBASE + 3) return VDP_W;
        return 0;
    endfunction

    always @(posedge clk) begin
        if (!clr) begin
            exp_wn     = 1'b1;
            exp_flag   = 1'b0;
            exp_wc     = 16'h0000;
            cyc_active = 1'b0;
            seen_seq   = cyc_seq;
        end else begin
            if (tmo_clr) exp_flag = 1'b0;
            if (cpu_ce) begin
                if (!exp_wn && exp_wc != 16'hFFFF) exp_wc = exp_wc + 16'd1;
                if (cyc_seq != seen_seq) begin
                    seen_seq   = cyc_seq;
                    cyc_active = 1'b1;
                    edge_j     = 0;
                end else if (cyc_active) begin
                    edge_j++;
                end
                exp_wn = 1'b1;
                if (cyc_active) begin
                    if (edge_j < exp_k) begin
                        exp_wn = 1'b0;
                    end else begin
                        if (exp_tmo) exp_flag = 1'b1;
                        cyc_active = 1'b0;
                    end
                end
                #1;
                check("model_wait_n", wait_n, exp_wn);
                check("model_timeout_flag", timeout_flag, exp_flag);
                check("model_wait_count", wait_count, STATS ? exp_wc : 16'h0000);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic ce_edge();
        @(posedge clk);
        while (!cpu_ce) @(posedge clk);
    endtask

    // v_ext: number of T-states (from the first cycle edge) ext_wait_n is low.
    task automatic run_vec(input string name, input logic v_m1, input logic v_mreq,
                           input logic v_iorq, input logic [7:0] v_addr, input logic v_turbo,
                           input int v_ext, input int k_hand, input logic tmo_hand);
        int n, k, low;
        bit tmo;
        n   = model_n(v_m1, v_mreq, v_iorq, v_addr, v_turbo);
        k   = (v_ext > n) ? ((v_ext < n + EXT_T) ? v_ext : n + EXT_T) : n;
        tmo = (v_ext > n + EXT_T);
        check({name, "_model_k"}, k, k_hand);
        @(negedge clk);
        exp_k      = k;
        exp_tmo    = tmo;
        m1_n       = v_m1;
        mreq_n     = v_mreq;
        iorq_n     = v_iorq;
        addr       = v_addr;
        turbo      = v_turbo;
        ext_wait_n = (v_ext > 0) ? 1'b0 : 1'b1;
        cyc_seq++;
        low = 0;
        for (int j = 0; j <= k_hand + 2; j++) begin
            ce_edge();
            #1;
            if (!wait_n) low++;
            @(negedge clk);
            if (j + 1 == v_ext) ext_wait_n = 1'b1;
        end
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
        ext_wait_n = 1'b1; turbo = 1'b0; addr = 8'h00;
        ce_edge();
        ce_edge();
        #1;
        check({name, "_low_periods"}, low, k_hand);
        check({name, "_timeout_flag"}, timeout_flag, tmo_hand);
        check({name, "_wait_n_idle"}, wait_n, 1'b1);
        $display("txn %-10s addr=%02h low=%0d flag=%0b count=%0d", name, v_addr, low,
                 timeout_flag, wait_count);
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1;
        check("reset_wait_n", wait_n, 1'b1);
        check("reset_timeout_flag", timeout_flag, 1'b0);
        check("reset_wait_count", wait_count, 16'h0000);
        @(negedge clk);
        clr = 1'b1;
        repeat (2) ce_edge();

        //        name        m1    mreq  iorq  addr   turbo ext  k    tmo
        run_vec("m1_fetch",  1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 0,   1,   1'b0);
        check("m1_wait_count", wait_count, STATS ? 16'd1 : 16'd0);
        run_vec("m1_turbo",  1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 0,   0,   1'b0);
        run_vec("out_99",    1'b1, 1'b1, 1'b0, 8'h99, 1'b0, 0,   2,   1'b0);
        run_vec("out_a0",    1'b1, 1'b1, 1'b0, 8'hA0, 1'b0, 0,   0,   1'b0);
        run_vec("inta_98",   1'b0, 1'b1, 1'b0, 8'h98, 1'b0, 0,   1,   1'b0);
        run_vec("io_a8_ext", 1'b1, 1'b1, 1'b0, 8'hA8, 1'b0, 5,   5,   1'b0);
        run_vec("ext_tmo",   1'b1, 1'b1, 1'b0, 8'hA8, 1'b0, 300, 255, 1'b1);

        @(negedge clk); tmo_clr = 1'b1;
        @(negedge clk); tmo_clr = 1'b0;
        #1;
        check("tmo_clr_flag", timeout_flag, 1'b0);

        run_vec("mem_9a",    1'b1, 1'b0, 1'b1, 8'h9A, 1'b0, 0,   0,   1'b0);
        run_vec("out_9b_ext",1'b1, 1'b1, 1'b0, 8'h9B, 1'b0, 4,   4,   1'b0);
        run_vec("m1_ext1",   1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1,   1,   1'b0);
        // 1+0+2+0+1+5+255+0+4+1
        check("total_wait_count", wait_count, STATS ? 16'd269 : 16'd0);

        // Reset in the middle of a VDP wait must release WAIT at once.
        @(negedge clk);
        exp_k = VDP_W; exp_tmo = 1'b0;
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b0; addr = 8'h98;
        cyc_seq++;
        ce_edge();
        #1;
        check("rst_pre_wait_n", wait_n, 1'b0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("rst_async_wait_n", wait_n, 1'b1);
        check("rst_async_wait_count", wait_count, 16'h0000);
        iorq_n = 1'b1; addr = 8'h00;
        repeat (4) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        repeat (2) ce_edge();
        $display("txn reset_mid addr=98 wait_n=%0b", wait_n);

        run_vec("m1_after",  1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 0,   1,   1'b0);
        check("after_rst_wait_count", wait_count, STATS ? 16'd1 : 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
